vz_loader: RTL and testbench

- Sequences a VZ image download from the HPS ioctl stream into Laser310 system RAM.
- Parses the 24-byte VZ header, holds the Z80 off the bus, and writes data bytes to RAM at the header start address through a req/ack memory port.
- For BASIC images it patches the BASIC program pointers.
- Sits between hps_io ioctl outputs and the RAM arbiter in LASER310_TOP.

---
 rtl/vz_pkg.sv | 32 +++
 rtl/vz_byte_fifo.sv | 55 +++++
 rtl/vz_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_vz_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vz_pkg.sv
// Shared types and constants for the VZ image loader.
package vz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WAIT_HOLD,
        DATA,
        PTR,
        FIN,
        ERR
    } vz_state_e;

    localparam int          VZ_HDR_LEN     = 24;
    // Magic words, first header byte in the top byte
    localparam logic [31:0] VZ_MAGIC_VZF0  = 32'h565A4630;
    localparam logic [31:0] VZ_MAGIC_BLANK = 32'h20200000;
    localparam logic [7:0]  VZ_TYPE_BASIC  = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_BIN    = 8'hF1;

    function automatic logic [7:0] magic_byte(input logic [31:0] m, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = m[31:24];
            2'd1:    b = m[23:16];
            2'd2:    b = m[15:8];
            default: b = m[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vz_byte_fifo.sv
// Small synchronous byte FIFO; DEPTH must be a power of two.
module vz_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rp_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vz_loader.sv
// VZ image loader: parses the header and streams ioctl bytes into RAM over req/ack.
// Optional VZ_AUTORUN_EN adds exec_req/exec_addr for binary images.
module vz_loader
    import vz_pkg::*;
#(
    parameter logic [7:0]  VZ_INDEX   = 8'd1,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PTR_START  = 16'h78A4,
    parameter logic [15:0] PTR_END    = 16'h78F9
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        dn_wait,
    output logic        cpu_hold,
    input  logic        hold_ack,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
`ifdef VZ_AUTORUN_EN
    output logic        exec_req,
    output logic [15:0] exec_addr,
`endif
    output logic        err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    vz_state_e     state_q;
    logic          dl_q;
    logic [4:0]    hidx_q;
    logic [15:0]   rx_cnt_q;
    logic          vzf_ok_q, alt_ok_q, vzf_ok_d, alt_ok_d;
    logic          is_basic_q;
    logic [15:0]   start_q, addr_q;
    logic          past_end_q, ovf_q;
    logic [1:0]    pidx_q;
    logic          req_q, busy_q, hold_q, done_q, err_q;
    logic [15:0]   maddr_q;
    logic [7:0]    mwdata_q;
`ifdef VZ_AUTORUN_EN
    logic          exec_q;
    logic [15:0]   exec_addr_q;
`endif

    logic [CW-1:0] fcount;
    logic [7:0]    fhead;
    logic          ffull, fempty;
    logic          start, push, pop, fclr, ord_bad, hdr_bad, go_err;
    logic [15:0]   ptr_word, ptr_base;

    assign start   = dn_download & ~dl_q & (dn_index == VZ_INDEX);
    assign push    = dn_wr & busy_q & ~start;
    assign ord_bad = push & (dn_addr != rx_cnt_q);
    assign fclr    = start | (state_q == ERR);
    assign dn_wait = (fcount >= CW'(FIFO_DEPTH - 1));
    assign go_err  = ord_bad | hdr_bad;

    assign ptr_word = pidx_q[1] ? addr_q : start_q;
    assign ptr_base = pidx_q[1] ? PTR_END : PTR_START;

    vz_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .clr_i   (fclr),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (dn_data),
        .dout_o  (fhead),
        .count_o (fcount),
        .full_o  (ffull),
        .empty_o (fempty)
    );

    always_comb begin
        vzf_ok_d = vzf_ok_q & (fhead == magic_byte(VZ_MAGIC_VZF0, hidx_q[1:0]));
        alt_ok_d = alt_ok_q & (fhead == magic_byte(VZ_MAGIC_BLANK, hidx_q[1:0]));
        hdr_bad  = 1'b0;
        pop      = 1'b0;
        case (state_q)
            HDR: begin
                pop = ~fempty;
                // Download ending with the header still incomplete is a truncation
                if (fempty)               hdr_bad = ~dn_download;
                else if (hidx_q < 5'd4)   hdr_bad = ~(vzf_ok_d | alt_ok_d);
                else if (hidx_q == 5'd21) hdr_bad = (fhead != VZ_TYPE_BASIC) && (fhead != VZ_TYPE_BIN);
            end
            DATA:    pop = req_q ? mem_ack : (~fempty & past_end_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            hidx_q     <= '0;
            rx_cnt_q   <= '0;
            vzf_ok_q   <= 1'b0;
            alt_ok_q   <= 1'b0;
            is_basic_q <= 1'b0;
            start_q    <= '0;
            addr_q     <= '0;
            past_end_q <= 1'b0;
            ovf_q      <= 1'b0;
            pidx_q     <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
`ifdef VZ_AUTORUN_EN
            exec_q      <= 1'b0;
            exec_addr_q <= '0;
`endif
        end else begin
            dl_q   <= dn_download;
            done_q <= 1'b0;
`ifdef VZ_AUTORUN_EN
            exec_q <= 1'b0;
`endif
            if (push)         rx_cnt_q <= rx_cnt_q + 16'd1;
            if (push & ffull) err_q    <= 1'b1;

            if (start) begin
                state_q    <= HDR;
                busy_q     <= 1'b1;
                hold_q     <= 1'b1;
                err_q      <= 1'b0;
                rx_cnt_q   <= '0;
                hidx_q     <= '0;
                vzf_ok_q   <= 1'b1;
                alt_ok_q   <= 1'b1;
                req_q      <= 1'b0;
                pidx_q     <= '0;
                past_end_q <= 1'b0;
                ovf_q      <= 1'b0;
`ifdef VZ_AUTORUN_EN
                exec_addr_q <= '0;
`endif
            end else if (go_err) begin
                state_q <= ERR;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                hold_q  <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    HDR: if (!fempty) begin
                        hidx_q <= hidx_q + 5'd1;
                        if (hidx_q < 5'd4) begin
                            vzf_ok_q <= vzf_ok_d;
                            alt_ok_q <= alt_ok_d;
                        end
                        if (hidx_q == 5'd21) is_basic_q   <= (fhead == VZ_TYPE_BASIC);
                        if (hidx_q == 5'd22) start_q[7:0] <= fhead;
                        if (hidx_q == 5'(VZ_HDR_LEN - 1)) begin
                            start_q[15:8] <= fhead;
                            addr_q        <= {fhead, start_q[7:0]};
                            state_q       <= WAIT_HOLD;
                        end
                    end
                    WAIT_HOLD: if (hold_ack) state_q <= DATA;
                    DATA: begin
                        if (req_q) begin
                            if (mem_ack) begin
                                req_q  <= 1'b0;
                                addr_q <= addr_q + 16'd1;
                                if (addr_q == 16'hFFFF) past_end_q <= 1'b1;
                            end
                        end else if (!fempty) begin
                            // Bytes beyond FFFF are popped and discarded by the pop logic
                            if (!past_end_q) begin
                                req_q    <= 1'b1;
                                maddr_q  <= addr_q;
                                mwdata_q <= fhead;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (!dn_download) begin
                            if (ovf_q) err_q <= 1'b1;
                            state_q <= is_basic_q ? PTR : FIN;
                            pidx_q  <= '0;
                        end
                    end
                    PTR: begin
                        if (req_q) begin
                            if (mem_ack) begin
                                req_q  <= 1'b0;
                                pidx_q <= pidx_q + 2'd1;
                                if (pidx_q == 2'd3) state_q <= FIN;
                            end
                        end else begin
                            req_q    <= 1'b1;
                            maddr_q  <= ptr_base + {15'd0, pidx_q[0]};
                            mwdata_q <= pidx_q[0] ? ptr_word[15:8] : ptr_word[7:0];
                        end
                    end
                    FIN: begin
                        done_q  <= ~err_q;
`ifdef VZ_AUTORUN_EN
                        exec_q  <= ~err_q & ~is_basic_q;
                        if (~err_q & ~is_basic_q) exec_addr_q <= start_q;
`endif
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    ERR: begin
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                        hold_q <= 1'b0;
                        err_q  <= 1'b1;
                        if (!dn_download) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;
`ifdef VZ_AUTORUN_EN
    assign exec_req  = exec_q;
    assign exec_addr = exec_addr_q;
`endif

endmodule

// File: tb/tb_vz_loader.sv
// Scoreboard bench for vz_loader: stimulus pushes expected RAM writes, a memory model checks them.
module tb_vz_loader;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dn_download, dn_wr, dn_wait, cpu_hold, hold_ack;
    logic [7:0]  dn_index, dn_data, mem_wdata;
    logic [15:0] dn_addr, mem_addr;
    logic        mem_req, mem_ack, busy, done, err;
`ifdef VZ_AUTORUN_EN
    logic        exec_req;
    logic [15:0] exec_addr;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stim_q[$];
    int          n_chk = 0, n_fail = 0;
    int          ack_lat = 1, hold_dly = 0;
    int          done_cnt = 0, exec_cnt = 0, off = 0;
    logic [15:0] exp_exec_addr = '0;

    always #5 clk_sys = ~clk_sys;

    vz_loader dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_index    (dn_index),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_wait     (dn_wait),
        .cpu_hold    (cpu_hold),
        .hold_ack    (hold_ack),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
`ifdef VZ_AUTORUN_EN
        .exec_req    (exec_req),
        .exec_addr   (exec_addr),
`endif
        .err         (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // CPU grants the bus hold_dly cycles after cpu_hold rises
    initial begin : hold_model
        int hc;
        hc = 0;
        hold_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (cpu_hold) begin
                if (hc < hold_dly) hc++;
                hold_ack = (hc >= hold_dly);
            end else begin
                hc = 0;
                hold_ack = 1'b0;
            end
        end
    end

    // RAM responder and scoreboard check
    initial begin : mem_model
        bit          act;
        int          w;
        logic [15:0] ha;
        logic [7:0]  hd;
        wr_t         e;
        act = 0; w = 0; ha = '0; hd = '0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            mem_ack = 1'b0;
            if (!mem_req || reset) begin
                act = 0;
            end else begin
                if (!act) begin
                    chk("req_after_hold", hold_ack, 1);
                    act = 1; w = 0; ha = mem_addr; hd = mem_wdata;
                end else begin
                    chk("req_stable", {mem_addr, mem_wdata}, {ha, hd});
                end
                w++;
                if (w >= ack_lat) begin
                    mem_ack = 1'b1;
                    act = 0;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_write: got %h=%h, expected no write", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", mem_addr, e.a);
                        chk("wr_data", mem_wdata, e.d);
                    end
                end
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk_sys);
            if (done) done_cnt++;
`ifdef VZ_AUTORUN_EN
            if (exec_req) begin
                exec_cnt++;
                chk("exec_with_done", done, 1);
                chk("exec_addr", exec_addr, exp_exec_addr);
            end
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic mk_hdr(input logic [7:0] typ, input logic [15:0] st, input bit alt);
        logic [31:0] m;
        m = alt ? 32'h20200000 : 32'h565A4630;
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(m[31-8*i -: 8]);
        for (int i = 0; i < 17; i++) stim_q.push_back(8'($urandom));
        stim_q.push_back(typ);
        stim_q.push_back(st[7:0]);
        stim_q.push_back(st[15:8]);
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a; w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic begin_dl();
        dn_index = 8'd1;
        dn_download = 1'b1;
        off = 0;
        cyc(1);
    endtask

    task automatic send(input logic [7:0] b, input bit ign, input int gap);
        int t;
        t = 0;
        if (!ign) begin
            while (dn_wait && t < 200) begin cyc(1); t++; end
            if (dn_wait) begin
                n_chk++; n_fail++;
                $display("FAIL wait_timeout: dn_wait stuck after %0d cycles", t);
            end
        end
        dn_wr = 1'b1; dn_addr = 16'(off); dn_data = b;
        cyc(1);
        dn_wr = 1'b0;
        off++;
        if (gap > 0) cyc($urandom_range(0, gap));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 5000) begin cyc(1); t++; end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", t);
        end
        cyc(2);
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        while (!mem_req && t < 300) begin cyc(1); t++; end
        chk("req_seen", mem_req, 1);
    endtask

    // Reference: data byte i lands at start+i unless past FFFF; BASIC adds pointer patch
    task automatic run_load(input logic [7:0] typ, input logic [15:0] st, input int n,
                            input bit alt, input int gap, input int lat, input int hdly);
        int  endv;
        bit  e_err;
        mk_hdr(typ, st, alt);
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
        endv  = int'(st) + n;
        e_err = (endv > 65536);
        for (int i = 0; i < n; i++)
            if (int'(st) + i <= 65535) push_exp(16'(int'(st) + i), stim_q[24+i]);
        if (typ == 8'hF0) begin
            push_exp(16'h78A4, st[7:0]);
            push_exp(16'h78A5, st[15:8]);
            push_exp(16'h78F9, 8'(endv));
            push_exp(16'h78FA, 8'(endv >> 8));
        end
        exp_exec_addr = st;
        done_cnt = 0; exec_cnt = 0;
        hold_dly = hdly;
        begin_dl();
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_err_clear", err, 0);
        chk("start_no_req", mem_req, 0);
        ack_lat = lat;
        foreach (stim_q[i]) send(stim_q[i], 0, gap);
        dn_download = 1'b0;
        wait_idle();
        chk("load_err", err, e_err);
        chk("load_done_cnt", done_cnt, e_err ? 0 : 1);
        chk("load_writes_left", exp_q.size(), 0);
        chk("load_hold_off", cpu_hold, 0);
`ifdef VZ_AUTORUN_EN
        chk("load_exec_cnt", exec_cnt, (typ == 8'hF1 && !e_err) ? 1 : 0);
`endif
    endtask

    initial begin
        reset = 1'b1; dn_download = 1'b0; dn_index = '0;
        dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cyc(3);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dn_wait", dn_wait, 0);
        chk("rst_mem_addr", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        cyc(2);

        run_load(8'hF0, 16'h7AE9, 5, 0, 0, 3, 0);
        run_load(8'hF1, 16'h8000, 300, 1, 0, 1, 10);

        // Bad magic: nothing written, bus released without waiting for the download
        mk_hdr(8'hF1, 16'h8000, 0);
        stim_q[0] = 8'h41;
        done_cnt = 0;
        begin_dl();
        foreach (stim_q[i]) send(stim_q[i], 0, 0);
        chk("magic_err", err, 1);
        chk("magic_busy", busy, 0);
        chk("magic_hold", cpu_hold, 0);
        dn_download = 1'b0;
        cyc(4);
        chk("magic_done_cnt", done_cnt, 0);
        chk("magic_err_sticky", err, 1);

        // Backpressure: head write stalls, FIFO fills, fifth byte is dropped
        mk_hdr(8'hF1, 16'h9000, 0);
        for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) push_exp(16'(16'h9000 + i), stim_q[24+i]);
        done_cnt = 0; hold_dly = 0;
        begin_dl();
        ack_lat = 50;
        for (int i = 0; i < 24; i++) send(stim_q[i], 0, 0);
        cyc(4);
        send(stim_q[24], 0, 0);
        send(stim_q[25], 0, 0);
        cyc(3);
        chk("bp_wait_at2", dn_wait, 0);
        send(stim_q[26], 0, 0);
        cyc(2);
        chk("bp_wait_at3", dn_wait, 1);
        chk("bp_err_before", err, 0);
        send(stim_q[27], 1, 0);
        send(stim_q[28], 1, 0);
        cyc(1);
        chk("bp_drop_err", err, 1);
        dn_download = 1'b0;
        wait_idle();
        chk("bp_done_cnt", done_cnt, 0);
        chk("bp_writes_left", exp_q.size(), 0);

        run_load(8'hF1, 16'hFFFE, 4, 0, 1, 2, 0);

        // Truncated header
        mk_hdr(8'hF0, 16'h7000, 0);
        done_cnt = 0;
        begin_dl();
        for (int i = 0; i < 10; i++) send(stim_q[i], 0, 0);
        dn_download = 1'b0;
        cyc(5);
        chk("trunc_err", err, 1);
        chk("trunc_busy", busy, 0);
        chk("trunc_hold", cpu_hold, 0);
        chk("trunc_done_cnt", done_cnt, 0);

        // Abort mid-DATA with err set, then a clean restart
        mk_hdr(8'hF1, 16'hA000, 1);
        begin_dl();
        ack_lat = 60;
        foreach (stim_q[i]) send(stim_q[i], 0, 0);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1, 0);
        wait_req();
        chk("abort_err_set", err, 1);
        exp_q.delete();
        dn_download = 1'b0;
        cyc(1);
        run_load(8'hF1, 16'hA100, 7, 0, 1, 2, 3);

        // Asynchronous reset while a write is pending
        mk_hdr(8'hF1, 16'hB000, 0);
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        begin_dl();
        ack_lat = 40;
        foreach (stim_q[i]) send(stim_q[i], 0, 0);
        wait_req();
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_hold", cpu_hold, 0);
        exp_q.delete();
        dn_download = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("arst_idle_req", mem_req, 0);

        run_load(8'hF1, 16'h9000, 0, 1, 0, 1, 0);
        run_load(8'hF0, 16'hC000, 0, 0, 0, 2, 0);
        for (int k = 0; k < 6; k++)
            run_load(($urandom_range(0, 1) != 0) ? 8'hF1 : 8'hF0,
                     16'(16'h8000 + $urandom_range(0, 16'h6000)),
                     $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 40));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
